// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port 16-bit word memory with a hardware stack. Accepts one request
//   at a time, waits LATENCY cycles, then presents a response. The response is
//   held until the requester consumes it.
//
//   Parameters
//     DEPTH_LOG2 : log2 of the word count (default 2048 words)
//     LATENCY    : cycles from the accepting edge to rsp_valid (1..7)
//
//   Ports
//     clk, reset            : clock and synchronous active-low reset
//     req_valid / req_ready : request handshake
//     req_write             : 1 = write, 0 = read (ignored for stack ops)
//     req_stack, req_push   : stack op; push writes mem[SP], pop reads mem[SP+1]
//     req_addr, req_wdata   : word address (non-stack ops) and write/push data
//     rsp_valid / rsp_ready : response handshake
//     rsp_rdata, rsp_error  : read/pop data (0 otherwise) and fault flag
//     sp_out                : current stack pointer, zero-extended
//
//   Build option
//     MEM_RSP_STACK_GUARD_EN : when defined, out-of-range addresses, push at
//     SP == 0 and pop at SP == TOP are rejected with rsp_error. When undefined,
//     addresses truncate and SP wraps.
module data_mem_responder #(
    parameter int DEPTH_LOG2 = 11,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_stack,
    input  logic        req_push,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic [15:0] sp_out
);
    localparam int                    DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] TOP   = '1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  sp_q, sp_d;
    logic                   op_stack_q, op_stack_d;
    logic                   op_push_q, op_push_d;
    logic                   op_write_q, op_write_d;
    logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [15:0]            mem [DEPTH];
    logic                   mem_we;
    logic [DEPTH_LOG2-1:0]  mem_waddr;
    logic [DEPTH_LOG2-1:0]  sp_inc, sp_dec;
    logic                   accept;
    logic                   fault;

    // Reset gates ready combinationally so no request can slip in on a
    // reset edge even though the state is already IDLE.
    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign sp_out    = 16'(sp_q);
    assign sp_inc    = sp_q + 1'b1;
    assign sp_dec    = sp_q - 1'b1;

`ifdef MEM_RSP_STACK_GUARD_EN
    logic oob_q, oob_d;

    // Out-of-range flag is captured with the request so the address
    // inputs are never looked at after the accepting edge.
    always_comb begin
        oob_d = oob_q;
        if (accept) oob_d = |(req_addr >> DEPTH_LOG2);
    end

    always_ff @(posedge clk) begin
        if (!reset) oob_q <= 1'b0;
        else        oob_q <= oob_d;
    end

    assign fault     = op_stack_q ? (op_push_q ? (sp_q == '0) : (sp_q == TOP)) : oob_q;
    assign rsp_error = err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^(req_addr >> DEPTH_LOG2);
    assign fault          = 1'b0;
    assign rsp_error      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sp_d       = sp_q;
        op_stack_d = op_stack_q;
        op_push_d  = op_push_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = sp_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = WAIT;
                    cnt_d      = 3'(LATENCY - 1);
                    op_stack_d = req_stack;
                    op_push_d  = req_push;
                    op_write_d = req_write;
                    addr_d     = req_addr[DEPTH_LOG2-1:0];
                    wdata_d    = req_wdata;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    // The access itself happens only on this edge.
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = fault;
                    if (!fault) begin
                        if (op_stack_q) begin
                            if (op_push_q) begin
                                mem_we    = 1'b1;
                                mem_waddr = sp_q;
                                sp_d      = sp_dec;
                            end else begin
                                sp_d    = sp_inc;
                                rdata_d = mem[sp_inc];
                            end
                        end else if (op_write_q) begin
                            mem_we    = 1'b1;
                            mem_waddr = addr_q;
                        end else begin
                            rdata_d = mem[addr_q];
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sp_q       <= TOP;
            op_stack_q <= 1'b0;
            op_push_q  <= 1'b0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sp_q       <= sp_d;
            op_stack_q <= op_stack_d;
            op_push_q  <= op_push_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Array is not reset; reset on the commit edge suppresses the write so an
    // aborted op leaves memory untouched.
    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[mem_waddr] <= wdata_q;
    end

endmodule
